// File: rtl/aes_pkg.sv
// AES-128 shared types: round count, round-key index and controller states.
// Used by the round controller, key schedule and datapath.
package aes_pkg;

  localparam int NR    = 10;
  localparam int RND_W = 4;

  typedef logic [RND_W-1:0] rk_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } ctrl_state_t;

  localparam rk_idx_t RK_FIRST = rk_idx_t'(1);
  localparam rk_idx_t RK_LAST  = rk_idx_t'(NR);

  function automatic logic is_last(input rk_idx_t r);
    return r == RK_LAST;
  endfunction

endpackage

// File: rtl/aes_rnd_counter.sv
// Round counter for the AES sequencer: clear, load-to-first-round,
// increment, and a terminal-count flag that also caps the count.
module aes_rnd_counter
  import aes_pkg::*;
#(
  parameter int TC = NR
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    clr_i,
  input  logic    ld_i,
  input  logic    inc_i,
  output rk_idx_t cnt_o,
  output logic    tc_o
);

  assign tc_o = (cnt_o == rk_idx_t'(TC));

  // Saturates at TC so the index can never run past the last round key.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_o <= '0;
    end else if (ld_i) begin
      cnt_o <= RK_FIRST;
    end else if (inc_i && !tc_o) begin
      cnt_o <= cnt_o + rk_idx_t'(1);
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round sequencer (load, NR rounds, hold result).
// Optional AES_KEY_STALL_EN adds rk_valid_i to stall on round-key availability.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
`ifdef AES_KEY_STALL_EN
  input  logic    rk_valid_i,
`endif
  input  logic    in_valid_i,
  output logic    in_ready_o,
  output logic    load_o,
  output logic    round_en_o,
  output logic    mix_en_o,
  output rk_idx_t rk_idx_o,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output logic    busy_o
);

  ctrl_state_t state;
  rk_idx_t     rnd;
  logic        rnd_tc;
  logic        key_ok;
  logic        st_idle;
  logic        st_round;
  logic        st_done;
  logic        step;
  logic        accept;

`ifdef AES_KEY_STALL_EN
  assign key_ok = rk_valid_i;
`else
  assign key_ok = 1'b1;
`endif

  assign st_idle  = (state == IDLE);
  assign st_round = (state == ROUND);
  assign st_done  = (state == DONE);

  assign load_o = in_valid_i & in_ready_o;
  assign step   = st_round & key_ok;
  assign accept = st_done & out_ready_i;

  aes_rnd_counter #(
    .TC (NR)
  ) u_rnd_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (accept),
    .ld_i  (load_o),
    .inc_i (step),
    .cnt_o (rnd),
    .tc_o  (rnd_tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_o) begin
            state  <= ROUND;
            busy_o <= 1'b1;
          end
        end
        ROUND: begin
          if (step && rnd_tc) begin
            state       <= DONE;
            out_valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  // Final round skips MixColumns; a stalled round issues no strobes.
  always_comb begin
    in_ready_o = 1'b0;
    round_en_o = 1'b0;
    mix_en_o   = 1'b0;
    rk_idx_o   = '0;
    unique case (1'b1)
      st_idle: begin
        in_ready_o = key_ok;
      end
      st_round: begin
        round_en_o = key_ok;
        mix_en_o   = key_ok & ~is_last(rnd);
        rk_idx_o   = rnd;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: strobe-driven AES datapath model plus
// ciphertext scoreboard and per-cycle strobe timeline checks.
module tb_aes_round_ctrl;
  import aes_pkg::*;

  logic    clk = 1'b0;
  logic    rst_i;
  logic    rk_valid;
  logic    in_valid;
  logic    in_ready_o;
  logic    load_o;
  logic    round_en_o;
  logic    mix_en_o;
  rk_idx_t rk_idx_o;
  logic    out_valid_o;
  logic    out_ready;
  logic    busy_o;

  logic [127:0] blk;
  logic [127:0] dp;
  logic [127:0] key;
  logic [127:0] rk [0:NR];
  logic [7:0]   sb [0:255];
  logic [127:0] sb_q [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
`ifdef AES_KEY_STALL_EN
    .rk_valid_i  (rk_valid),
`endif
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready_o),
    .load_o      (load_o),
    .round_en_o  (round_en_o),
    .mix_en_o    (mix_en_o),
    .rk_idx_o    (rk_idx_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic build_keys();
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_rnd(input logic [127:0] s,
                                           input logic [127:0] k,
                                           input logic mix);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++) b[j+4*c] = a[j+4*((c+j)%4)];
    if (mix) begin
      for (int c = 0; c < 4; c++) begin
        a[4*c]   = xt(b[4*c]) ^ gm(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
        a[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ gm(b[4*c+2], 8'h03) ^ b[4*c+3];
        a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ gm(b[4*c+3], 8'h03);
        a[4*c+3] = gm(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
      end
      for (int i = 0; i < 16; i++) b[i] = a[i];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r <= NR; r++) s = aes_rnd(s, rk[r], r != NR);
    return s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Datapath driven purely by the controller strobes.
  always @(posedge clk) begin
    if (load_o) dp <= blk ^ rk[0];
    else if (round_en_o) dp <= aes_rnd(dp, rk[rk_idx_o], mix_en_o);
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      chk("excl", 128'(round_en_o & load_o), 128'(0));
      chk("mix_gate", 128'(mix_en_o & ~round_en_o), 128'(0));
      if (out_valid_o && out_ready) begin
        if (sb_q.size() == 0) chk("sb_extra", 128'(out_valid_o), 128'(0));
        else chk("ct", dp, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    @(negedge clk);
    chk({tag, "_rdy"}, 128'(in_ready_o), 128'(1));
    chk({tag, "_load"}, 128'(load_o), 128'(0));
    chk({tag, "_rnd"}, 128'(round_en_o), 128'(0));
    chk({tag, "_mix"}, 128'(mix_en_o), 128'(0));
    chk({tag, "_ov"}, 128'(out_valid_o), 128'(0));
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_idx"}, 128'(rk_idx_o), 128'(0));
  endtask

  // Enters on an IDLE cycle, returns on the IDLE cycle after accept.
  task automatic run_block(input logic [127:0] b, input logic [127:0] ct,
                           input int hold, input bit keep,
                           input int sa, input int sl);
    int idx;
    bit stl;
    blk = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    rk_valid = 1'b1;
    sb_q.push_back(ct);
    @(negedge clk);
    chk("gap_rdy", 128'(in_ready_o), 128'(1));
    chk("gap_busy", 128'(busy_o), 128'(0));
    chk("load", 128'(load_o), 128'(1));
    chk("load_idx", 128'(rk_idx_o), 128'(0));
    for (int k = 1; k <= NR + sl; k++) begin
      tick();
      in_valid = keep;
      stl = (sl > 0) && (k >= sa) && (k < sa + sl);
      idx = (sl == 0 || k < sa) ? k : (stl ? sa : k - sl);
      rk_valid = !stl;
      @(negedge clk);
      chk("rnd_en", 128'(round_en_o), 128'(!stl));
      chk("rnd_idx", 128'(rk_idx_o), 128'(idx));
      chk("rnd_mix", 128'(mix_en_o), 128'(!stl && idx != NR));
      chk("rnd_load", 128'(load_o), 128'(0));
      chk("rnd_rdy", 128'(in_ready_o), 128'(0));
      chk("rnd_busy", 128'(busy_o), 128'(1));
      chk("rnd_ov", 128'(out_valid_o), 128'(0));
    end
    for (int h = 0; h <= hold; h++) begin
      tick();
      out_ready = (h == hold);
      @(negedge clk);
      chk("done_ov", 128'(out_valid_o), 128'(1));
      chk("done_rdy", 128'(in_ready_o), 128'(0));
      chk("done_rnd", 128'(round_en_o), 128'(0));
      chk("done_load", 128'(load_o), 128'(0));
      chk("done_busy", 128'(busy_o), 128'(1));
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] b;
    rst_i = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rk_valid = 1'b1;
    blk = '0;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    build_sbox();
    build_keys();

    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle_chk("rst");

    tick();
    run_block(128'h3243f6a8885a308d313198a2e0370734,
              128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0, 0, 0);

    b = rnd128();
    run_block(b, aes_ref(b), 5, 1'b0, 0, 0);

    b = rnd128();
    run_block(b, aes_ref(b), 0, 1'b1, 0, 0);
    b = rnd128();
    run_block(b, aes_ref(b), 0, 1'b0, 0, 0);
    in_valid = 1'b0;
    idle_chk("gap");

    tick();
    blk = rnd128();
    in_valid = 1'b1;
    @(negedge clk);
    chk("r5_load", 128'(load_o), 128'(1));
    for (int k = 1; k <= 5; k++) begin
      tick();
      in_valid = 1'b0;
      if (k == 5) rst_i = 1'b1;
      @(negedge clk);
      chk("r5_idx", 128'(rk_idx_o), 128'(k));
    end
    tick();
    rst_i = 1'b0;
    idle_chk("r5");
    repeat (NR + 4) begin
      tick();
      @(negedge clk);
      chk("r5_ov", 128'(out_valid_o), 128'(0));
    end

`ifdef AES_KEY_STALL_EN
    tick();
    rk_valid = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("kst_rdy", 128'(in_ready_o), 128'(0));
    chk("kst_load", 128'(load_o), 128'(0));
    tick();
    b = rnd128();
    run_block(b, aes_ref(b), 0, 1'b0, 4, 3);
    in_valid = 1'b0;
    idle_chk("kst");
`endif

    tick();
    idle_chk("end");
    chk("sb_drain", 128'(sb_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
